// File: rtl/regfile_wb_pkg.sv
// Shared types and constants for the regfile write-back arbiter.
package regfile_wb_pkg;

  localparam int ADDR_WIDTH    = 5;
  localparam int WB_DATA_WIDTH = 64;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]    addr;
    logic [WB_DATA_WIDTH-1:0] data;
  } wb_req_t;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/rr_multi_grant.sv
// Combinational round-robin picker that hands up to NR_WRITE_PORTS grants per cycle
// to write-back requesters, skipping same-address collisions and filtering x0 writes.
module rr_multi_grant
  import regfile_wb_pkg::*;
#(
  parameter int NR_REQ         = 4,
  parameter int NR_WRITE_PORTS = 2,
  parameter int PTR_WIDTH      = 2,
  parameter bit ZERO_REG_ZERO  = 1'b1
) (
  input  logic [NR_REQ-1:0]                         valid,
  input  logic [NR_REQ-1:0][ADDR_WIDTH-1:0]         addr,
  input  logic [PTR_WIDTH-1:0]                      ptr,
  output logic [NR_REQ-1:0]                         grant,
  output logic [NR_WRITE_PORTS-1:0][PTR_WIDTH-1:0]  port_sel,
  output logic [NR_WRITE_PORTS-1:0]                 port_we,
  output logic [PTR_WIDTH-1:0]                      next_ptr
);

  logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0] taken_addr;
  logic [PTR_WIDTH-1:0]                      idx;
  logic                                      is_zero;
  logic                                      clash;
  int                                        n_granted;
  int                                        sum;

  always_comb begin
    grant      = '0;
    port_sel   = '0;
    port_we    = '0;
    taken_addr = '0;
    next_ptr   = ptr;
    n_granted  = 0;
    idx        = '0;
    is_zero    = 1'b0;
    clash      = 1'b0;
    sum        = 0;
    for (int i = 0; i < NR_REQ; i++) begin
      sum = int'(ptr) + i;
      if (sum >= NR_REQ) sum = sum - NR_REQ;
      idx     = PTR_WIDTH'(sum);
      is_zero = ZERO_REG_ZERO && (addr[idx] == '0);
      // Only ports that will really write take part in collision checks,
      // so an x0 slot never blocks a later real write.
      clash = 1'b0;
      for (int k = 0; k < NR_WRITE_PORTS; k++) begin
        if (port_we[k] && (taken_addr[k] == addr[idx])) clash = 1'b1;
      end
      if (valid[idx] && (n_granted < NR_WRITE_PORTS) && !clash) begin
        grant[idx] = 1'b1;
        for (int k = 0; k < NR_WRITE_PORTS; k++) begin
          if (k == n_granted) begin
            port_sel[k]   = idx;
            port_we[k]    = !is_zero;
            taken_addr[k] = addr[idx];
          end
        end
        n_granted = n_granted + 1;
        next_ptr  = (int'(idx) == NR_REQ - 1) ? '0 : idx + PTR_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates write-back requesters onto the integer regfile write ports and
// zero-sweeps every architectural register after reset or on request.
//
// state | meaning
// INIT  | sweeping zeros over all registers, requesters held off
// RUN   | round-robin arbitration of write-back requests
module regfile_wb_arbiter
  import regfile_wb_pkg::*;
#(
  parameter int NR_REQ         = 4,
  parameter int NR_WRITE_PORTS = 2,
  parameter int DATA_WIDTH     = 64,
  parameter int NUM_WORDS      = 32,
  parameter bit ZERO_REG_ZERO  = 1'b1
) (
  input  logic                                       clk_i,
  input  logic                                       rst_ni,
  input  logic                                       init_req_i,
  output logic                                       init_done_o,
  input  logic [NR_REQ-1:0]                          req_valid_i,
  input  logic [NR_REQ-1:0][ADDR_WIDTH-1:0]          req_addr_i,
  input  logic [NR_REQ-1:0][DATA_WIDTH-1:0]          req_data_i,
  output logic [NR_REQ-1:0]                          req_ready_o,
  output logic [NR_WRITE_PORTS-1:0][ADDR_WIDTH-1:0]  waddr_o,
  output logic [NR_WRITE_PORTS-1:0][DATA_WIDTH-1:0]  wdata_o,
  output logic [NR_WRITE_PORTS-1:0]                  we_o
);

  localparam int PW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;
  localparam int CW = $clog2(NUM_WORDS + NR_WRITE_PORTS);

  state_e                             state_q, state_d;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic [PW-1:0]                      ptr_q, ptr_d;
  logic [NR_REQ-1:0]                  grant;
  logic [NR_WRITE_PORTS-1:0][PW-1:0]  port_sel;
  logic [NR_WRITE_PORTS-1:0]          port_we;
  logic [PW-1:0]                      next_ptr;
  logic [NR_WRITE_PORTS-1:0]          we_d;
  wb_req_t [NR_WRITE_PORTS-1:0]       port_d;

  rr_multi_grant #(
    .NR_REQ         (NR_REQ),
    .NR_WRITE_PORTS (NR_WRITE_PORTS),
    .PTR_WIDTH      (PW),
    .ZERO_REG_ZERO  (ZERO_REG_ZERO)
  ) u_pick (
    .valid    (req_valid_i),
    .addr     (req_addr_i),
    .ptr      (ptr_q),
    .grant    (grant),
    .port_sel (port_sel),
    .port_we  (port_we),
    .next_ptr (next_ptr)
  );

  assign init_done_o = (state_q == RUN);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ptr_d       = ptr_q;
    we_d        = '0;
    req_ready_o = '0;
    // Idle ports keep their last address/data; only we drops.
    for (int p = 0; p < NR_WRITE_PORTS; p++) begin
      port_d[p].addr = waddr_o[p];
      port_d[p].data = WB_DATA_WIDTH'(wdata_o[p]);
    end
    case (state_q)
      INIT: begin
        for (int p = 0; p < NR_WRITE_PORTS; p++) begin
          if (int'(cnt_q) + p < NUM_WORDS) begin
            we_d[p]        = 1'b1;
            port_d[p].addr = ADDR_WIDTH'(int'(cnt_q) + p);
            port_d[p].data = '0;
          end
        end
        if (int'(cnt_q) + NR_WRITE_PORTS >= NUM_WORDS) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(NR_WRITE_PORTS);
        end
      end
      RUN: begin
        if (init_req_i) begin
          state_d = INIT;
          cnt_d   = '0;
          ptr_d   = '0;
        end else begin
          req_ready_o = grant;
          ptr_d       = next_ptr;
          for (int p = 0; p < NR_WRITE_PORTS; p++) begin
            if (port_we[p]) begin
              we_d[p]        = 1'b1;
              port_d[p].addr = req_addr_i[port_sel[p]];
              port_d[p].data = WB_DATA_WIDTH'(req_data_i[port_sel[p]]);
            end
          end
        end
      end
      default: state_d = INIT;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= INIT;
      cnt_q   <= '0;
      ptr_q   <= '0;
      we_o    <= '0;
      waddr_o <= '0;
      wdata_o <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      we_o    <= we_d;
      for (int p = 0; p < NR_WRITE_PORTS; p++) begin
        waddr_o[p] <= port_d[p].addr;
        wdata_o[p] <= port_d[p].data[DATA_WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: reset, zero sweep, arbitration
// vectors, re-init and asynchronous reset during the sweep.
module tb_regfile_wb_arbiter;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 init_req = 1'b0;
  logic                 done;
  logic [3:0]           valid = '0;
  logic [3:0][4:0]      addr = '0;
  logic [3:0][63:0]     data = '0;
  logic [3:0]           ready;
  logic [1:0][4:0]      waddr;
  logic [1:0][63:0]     wdata;
  logic [1:0]           we;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [1:0]       we;
    logic [1:0][4:0]  wa;
    logic [1:0][63:0] wd;
    logic             done;
  } out_t;

  typedef struct {
    logic [3:0]      v;
    logic [3:0][4:0] a;
    logic [3:0]      rdy;
    logic [1:0]      we;
    logic [1:0][4:0] wa;
    int              ws1;
    int              ws0;
  } vec_t;

  out_t sb[$];
  vec_t vecs[11];

  regfile_wb_arbiter dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .init_req_i  (init_req),
    .init_done_o (done),
    .req_valid_i (valid),
    .req_addr_i  (addr),
    .req_data_i  (data),
    .req_ready_o (ready),
    .waddr_o     (waddr),
    .wdata_o     (wdata),
    .we_o        (we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] dat(input int vi, input int r);
    return {16'hA5A5, 16'(vi), 16'h5A5A, 16'(r)};
  endfunction

  function automatic out_t mko(input logic [1:0] w, input logic [1:0][4:0] a,
                               input logic [1:0][63:0] d, input logic dn);
    out_t o;
    o.we = w; o.wa = a; o.wd = d; o.done = dn;
    return o;
  endfunction

  function automatic out_t sweep_exp(input int j);
    logic [1:0][4:0] a;
    a[0] = 5'(2 * j);
    a[1] = 5'(2 * j + 1);
    return mko(2'b11, a, '0, j == 15);
  endfunction

  function automatic vec_t mkv(input logic [3:0] v, input logic [3:0][4:0] a, input logic [3:0] rdy,
                               input logic [1:0] w, input logic [1:0][4:0] wa, input int ws1, input int ws0);
    vec_t x;
    x.v = v; x.a = a; x.rdy = rdy; x.we = w; x.wa = wa; x.ws1 = ws1; x.ws0 = ws0;
    return x;
  endfunction

  // Drive one cycle of stimulus just after a falling edge, check the
  // combinational grant, queue what the ports must show after the next
  // rising edge, then compare at the following falling edge.
  task automatic step(input logic [3:0] v, input logic [3:0][4:0] a, input logic [3:0][63:0] d,
                      input logic ireq, input logic [3:0] rdy, input out_t e, input string tag);
    out_t x;
    valid = v; addr = a; data = d; init_req = ireq;
    #1;
    chk({tag, " ready"}, 64'(ready), 64'(rdy));
    sb.push_back(e);
    @(negedge clk);
    init_req = 1'b0;
    x = sb.pop_front();
    chk({tag, " we"}, 64'(we), 64'(x.we));
    chk({tag, " init_done"}, 64'(done), 64'(x.done));
    for (int p = 0; p < 2; p++) begin
      if (x.we[p]) begin
        chk($sformatf("%s waddr%0d", tag, p), 64'(waddr[p]), 64'(x.wa[p]));
        chk($sformatf("%s wdata%0d", tag, p), wdata[p], x.wd[p]);
      end
    end
  endtask

  task automatic full_sweep(input logic [3:0] v, input logic [3:0][4:0] a,
                            input logic [3:0][63:0] d, input string tag);
    for (int j = 0; j < 16; j++) step(v, a, d, 1'b0, 4'b0000, sweep_exp(j), $sformatf("%s%0d", tag, j));
  endtask

  initial begin
    logic [3:0][63:0] d;
    out_t e;

    vecs[0]  = mkv(4'b1111, {5'd8, 5'd7, 5'd6, 5'd5},    4'b0011, 2'b11, {5'd6, 5'd5},   1, 0);
    vecs[1]  = mkv(4'b1100, {5'd8, 5'd7, 5'd6, 5'd5},    4'b1100, 2'b11, {5'd8, 5'd7},   3, 2);
    vecs[2]  = mkv(4'b0111, {5'd0, 5'd10, 5'd9, 5'd9},   4'b0101, 2'b11, {5'd10, 5'd9},  2, 0);
    vecs[3]  = mkv(4'b0010, {5'd0, 5'd0, 5'd9, 5'd0},    4'b0010, 2'b01, {5'd0, 5'd9},   0, 1);
    vecs[4]  = mkv(4'b1000, {5'd12, 5'd0, 5'd0, 5'd0},   4'b1000, 2'b01, {5'd0, 5'd12},  0, 3);
    vecs[5]  = mkv(4'b0011, {5'd0, 5'd0, 5'd3, 5'd0},    4'b0011, 2'b10, {5'd3, 5'd0},   1, 0);
    vecs[6]  = mkv(4'b0000, {5'd1, 5'd2, 5'd3, 5'd4},    4'b0000, 2'b00, {5'd0, 5'd0},   0, 0);
    vecs[7]  = mkv(4'b0001, {5'd0, 5'd0, 5'd0, 5'd4},    4'b0001, 2'b01, {5'd0, 5'd4},   0, 0);
    vecs[8]  = mkv(4'b1111, {5'd20, 5'd0, 5'd0, 5'd21},  4'b0110, 2'b00, {5'd0, 5'd0},   0, 0);
    vecs[9]  = mkv(4'b1111, {5'd21, 5'd22, 5'd22, 5'd21}, 4'b1010, 2'b11, {5'd22, 5'd21}, 1, 3);
    vecs[10] = mkv(4'b0111, {5'd0, 5'd0, 5'd15, 5'd15},  4'b0101, 2'b10, {5'd15, 5'd0},  0, 0);

    // Reset held with requests pending: everything quiet.
    valid = 4'b1111;
    repeat (3) @(negedge clk);
    chk("rst we", 64'(we), 64'(0));
    chk("rst waddr", 64'(waddr), 64'(0));
    chk("rst wdata", wdata[0] | wdata[1], 64'(0));
    chk("rst init_done", 64'(done), 64'(0));
    chk("rst ready", 64'(ready), 64'(0));
    valid = '0;
    rst_n = 1'b1;

    full_sweep('0, '0, '0, "sweep");
    step('0, '0, '0, 1'b0, 4'b0000, mko(2'b00, '0, '0, 1'b1), "post_sweep");

    for (int i = 0; i < 11; i++) begin
      for (int r = 0; r < 4; r++) d[r] = dat(i, r);
      e = mko(vecs[i].we, vecs[i].wa, {dat(i, vecs[i].ws1), dat(i, vecs[i].ws0)}, 1'b1);
      step(vecs[i].v, vecs[i].a, d, 1'b0, vecs[i].rdy, e, $sformatf("vec%0d", i));
    end

    // Re-init from RUN with requesters waiting; pointer must restart at 0.
    for (int r = 0; r < 4; r++) d[r] = dat(20, r);
    step(4'b0111, {5'd0, 5'd19, 5'd18, 5'd17}, d, 1'b1, 4'b0000, mko(2'b00, '0, '0, 1'b0), "init_req");
    full_sweep(4'b0111, {5'd0, 5'd19, 5'd18, 5'd17}, d, "resweep");
    step(4'b0111, {5'd0, 5'd19, 5'd18, 5'd17}, d, 1'b0, 4'b0011,
         mko(2'b11, {5'd18, 5'd17}, {d[1], d[0]}, 1'b1), "after_init");
    step('0, '0, '0, 1'b0, 4'b0000, mko(2'b00, '0, '0, 1'b1), "idle");

    // Asynchronous reset partway through a sweep.
    step('0, '0, '0, 1'b1, 4'b0000, mko(2'b00, '0, '0, 1'b0), "init_req2");
    for (int j = 0; j < 7; j++) step('0, '0, '0, 1'b0, 4'b0000, sweep_exp(j), $sformatf("part%0d", j));
    valid = 4'b1111;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst we", 64'(we), 64'(0));
    chk("midrst waddr", 64'(waddr), 64'(0));
    chk("midrst init_done", 64'(done), 64'(0));
    chk("midrst ready", 64'(ready), 64'(0));
    @(negedge clk);
    valid = '0;
    rst_n = 1'b1;
    full_sweep('0, '0, '0, "rst_sweep");
    step('0, '0, '0, 1'b0, 4'b0000, mko(2'b00, '0, '0, 1'b1), "rst_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
